// File: rtl/cnn_window_gen_if.sv
// Pixel-stream and window-output bundle for cnn_window_gen.
// master drives the pixel stream; slave is the window generator.
interface cnn_window_gen_if #(
    parameter int DATA_W = 9,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam int WIN_W = K * K * DATA_W;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              frame_sync;
    logic              out_valid;
    logic [WIN_W-1:0]  out_window;
    logic [ROW_W-1:0]  out_row;
    logic [COL_W-1:0]  out_col;
    logic              frame_done;

    modport master (
        output in_valid, in_data, frame_sync,
        input  out_valid, out_window, out_row, out_col, frame_done
    );

    modport slave (
        input  in_valid, in_data, frame_sync,
        output out_valid, out_window, out_row, out_col, frame_done
    );
endinterface

// File: rtl/cnn_window_gen.sv
// K x K sliding-window generator over a raster pixel stream with K-1 line buffers.
// Define CNN_WIN_STRIDE2_EN to keep only windows on even row/column offsets (stride 2).
module cnn_window_gen #(
    parameter int DATA_W = 9,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5
) (
    input  logic                clk,
    input  logic                rstn,
    cnn_window_gen_if.slave     bus
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam int WIN_W = K * K * DATA_W;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);

    logic [ROW_W-1:0] row_reg, row_next, row_cur;
    logic [COL_W-1:0] col_reg, col_next, col_cur;
    logic             win_hit, last_pix;

    logic [WIN_W-1:0] win_reg, win_next;
    logic             out_valid_reg, frame_done_reg;
    logic [WIN_W-1:0] out_window_reg;
    logic [ROW_W-1:0] out_row_reg;
    logic [COL_W-1:0] out_col_reg;

    logic [K-2:0][DATA_W-1:0] lb_in, lb_out;

    // Position of the pixel on the bus this cycle; a resync forces it to (0,0).
    always_comb begin
        row_cur  = bus.frame_sync ? '0 : row_reg;
        col_cur  = bus.frame_sync ? '0 : col_reg;
        row_next = row_reg;
        col_next = col_reg;
        if (bus.in_valid) begin
            if (col_cur == COL_LAST) begin
                col_next = '0;
                row_next = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
            end else begin
                col_next = col_cur + 1'b1;
                row_next = row_cur;
            end
        end
        win_hit  = (row_cur >= ROW_FIRST) && (col_cur >= COL_FIRST);
`ifdef CNN_WIN_STRIDE2_EN
        win_hit  = win_hit && (row_cur[0] == ROW_FIRST[0]) && (col_cur[0] == COL_FIRST[0]);
`else
        win_hit  = win_hit;
`endif
        last_pix = (row_cur == ROW_LAST) && (col_cur == COL_LAST);
    end

    assign lb_in[0] = bus.in_data;

    genvar gi, gj;
    generate
        for (gi = 1; gi < K - 1; gi++) begin : g_cascade
            assign lb_in[gi] = lb_out[gi-1];
        end

        // Read address is the next pixel's column, so the registered read already
        // holds the previous-row pixel when that pixel arrives.
        for (gi = 0; gi < K - 1; gi++) begin : g_line
            logic [DATA_W-1:0] mem [IMG_W];
            logic [DATA_W-1:0] rd_reg;
            always_ff @(posedge clk) begin
                if (bus.in_valid)
                    mem[col_cur] <= lb_in[gi];
                rd_reg <= mem[col_next];
            end
            assign lb_out[gi] = rd_reg;
        end

        // Shift one column left; the new right column is oldest buffer at top, pixel at bottom.
        for (gi = 0; gi < K; gi++) begin : g_row
            for (gj = 0; gj < K; gj++) begin : g_col
                if (gj < K - 1) begin : g_shift
                    assign win_next[(gi*K+gj)*DATA_W +: DATA_W] = win_reg[(gi*K+gj+1)*DATA_W +: DATA_W];
                end else if (gi < K - 1) begin : g_buf
                    assign win_next[(gi*K+gj)*DATA_W +: DATA_W] = lb_out[K-2-gi];
                end else begin : g_pix
                    assign win_next[(gi*K+gj)*DATA_W +: DATA_W] = bus.in_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_reg        <= '0;
            col_reg        <= '0;
            win_reg        <= '0;
            out_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            out_window_reg <= '0;
            out_row_reg    <= '0;
            out_col_reg    <= '0;
        end else begin
            row_reg        <= row_next;
            col_reg        <= col_next;
            out_valid_reg  <= bus.in_valid && win_hit;
            frame_done_reg <= bus.in_valid && last_pix;
            if (bus.in_valid)
                win_reg <= win_next;
            if (bus.in_valid && win_hit) begin
                out_window_reg <= win_next;
                out_row_reg    <= row_cur;
                out_col_reg    <= col_cur;
            end
        end
    end

    assign bus.out_valid  = out_valid_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.out_window = out_window_reg;
    assign bus.out_row    = out_row_reg;
    assign bus.out_col    = out_col_reg;
endmodule

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench for cnn_window_gen: K=3 on a 5x5 image of raster-index pixels.
module tb_cnn_window_gen;
    localparam int DATA_W = 9;
    localparam int IMG_W  = 5;
    localparam int IMG_H  = 5;
    localparam int K      = 3;
    localparam int WIN_W  = K * K * DATA_W;
`ifdef CNN_WIN_STRIDE2_EN
    localparam int WINS_FRAME = 4;
    localparam int WINS_T4    = 7;
    localparam int WINS_PRE_RST = 1;
`else
    localparam int WINS_FRAME = 9;
    localparam int WINS_T4    = 17;
    localparam int WINS_PRE_RST = 2;
`endif

    typedef struct {
        logic [WIN_W-1:0] win;
        int               r;
        int               c;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    cnn_window_gen_if #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) bus ();

    cnn_window_gen #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   fd_count = 0;
    int   win_count = 0;
    int   mr = 0;
    int   mc = 0;
    bit   last_iv = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Window whose bottom-right pixel sits at (r,c): element (i,j) is pixel (r-K+1+i, c-K+1+j).
    function automatic logic [WIN_W-1:0] exp_win(input int r, input int c);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w[(i*K+j)*DATA_W +: DATA_W] = DATA_W'((r - K + 1 + i) * IMG_W + (c - K + 1 + j));
        return w;
    endfunction

    task automatic send(input int data, input bit fs);
        bit   hit;
        exp_t e;
        @(posedge clk); #1;
        bus.in_valid   = 1'b1;
        bus.in_data    = DATA_W'(data);
        bus.frame_sync = fs;
        if (fs) begin
            mr = 0;
            mc = 0;
        end
        hit = (mr >= K - 1) && (mc >= K - 1);
`ifdef CNN_WIN_STRIDE2_EN
        hit = hit && ((mr - (K - 1)) % 2 == 0) && ((mc - (K - 1)) % 2 == 0);
`endif
        if (hit) begin
            e.win = exp_win(mr, mc);
            e.r   = mr;
            e.c   = mc;
            q.push_back(e);
        end
        if (mc == IMG_W - 1) begin
            mc = 0;
            mr = (mr == IMG_H - 1) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.frame_sync = 1'b0;
        bus.in_data    = DATA_W'($urandom_range(0, 511));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({name, "_pending"}, 128'(q.size()), 128'(0));
        q.delete();
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_out_valid"},  128'(bus.out_valid),  128'(0));
        check({name, "_frame_done"}, 128'(bus.frame_done), 128'(0));
        check({name, "_out_row"},    128'(bus.out_row),    128'(0));
        check({name, "_out_col"},    128'(bus.out_col),    128'(0));
        check({name, "_out_window"}, 128'(bus.out_window), 128'(0));
    endtask

    always @(posedge clk) last_iv <= bus.in_valid;

    // Monitor: pops the scoreboard for each presented window, independent of stimulus.
    always @(negedge clk) begin
        if (rstn) begin
            if (!last_iv)
                check("out_valid_after_idle", 128'(bus.out_valid), 128'(0));
            if (bus.frame_done)
                fd_count++;
            if (bus.out_valid) begin
                win_count++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_window: got window at row %0d col %0d, expected none",
                             bus.out_row, bus.out_col);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("window", 128'(bus.out_window), 128'(e.win));
                    check("out_row", 128'(bus.out_row), 128'(e.r));
                    check("out_col", 128'(bus.out_col), 128'(e.c));
                    $display("window row=%0d col=%0d data=%0h", bus.out_row, bus.out_col, bus.out_window);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.frame_sync = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rstn = 1'b1;

        // Continuous ramp with sync on pixel 0.
        fd_count = 0; win_count = 0;
        for (int p = 0; p < 25; p++) send(p, p == 0);
        idle();
        drain("ramp");
        check("ramp_frame_done", 128'(fd_count), 128'(1));
        check("ramp_windows", 128'(win_count), 128'(WINS_FRAME));

        // Same ramp with a bubble after every pixel.
        fd_count = 0; win_count = 0;
        for (int p = 0; p < 25; p++) begin
            send(p, p == 0);
            idle();
        end
        drain("gappy");
        check("gappy_frame_done", 128'(fd_count), 128'(1));
        check("gappy_windows", 128'(win_count), 128'(WINS_FRAME));

        // Resync on pixel 7 abandons the partial frame.
        fd_count = 0; win_count = 0;
        for (int p = 0; p < 7; p++) send(p, p == 0);
        for (int p = 0; p < 25; p++) send(p, p == 0);
        idle();
        drain("resync7");
        check("resync7_frame_done", 128'(fd_count), 128'(1));
        check("resync7_windows", 128'(win_count), 128'(WINS_FRAME));

        // Resync landing on the last pixel of a frame suppresses frame_done.
        fd_count = 0; win_count = 0;
        for (int p = 0; p < 24; p++) send(p, p == 0);
        for (int p = 0; p < 25; p++) send(p, p == 0);
        idle();
        drain("resync_last");
        check("resync_last_frame_done", 128'(fd_count), 128'(1));
        check("resync_last_windows", 128'(win_count), 128'(WINS_T4));

        // Asynchronous reset mid-frame, then a ramp without frame_sync.
        fd_count = 0; win_count = 0;
        for (int p = 0; p < 14; p++) send(p, p == 0);
        idle();
        drain("pre_reset");
        check("pre_reset_windows", 128'(win_count), 128'(WINS_PRE_RST));
        #2 rstn = 1'b0;
        #1 check_zero_outputs("async_reset");
        mr = 0; mc = 0;
        @(negedge clk);
        rstn = 1'b1;
        fd_count = 0; win_count = 0;
        for (int p = 0; p < 25; p++) send(p, 1'b0);
        idle();
        drain("post_reset");
        check("post_reset_frame_done", 128'(fd_count), 128'(1));
        check("post_reset_windows", 128'(win_count), 128'(WINS_FRAME));

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
